// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and counter sizing. Optional subtract mode is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must index bits 0..WIDTH-1; never narrower than one bit.
  function automatic int cntWidth(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cntWidth(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder used as the serial adder's arithmetic core.
module full_adder_cell (
  input  logic Ai,
  input  logic Bi,
  input  logic Ci,
  output logic F,
  output logic C
);

  assign F = Ai ^ Bi ^ Ci;
  assign C = (Ai & Bi) | (Ci & (Ai ^ Bi));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder cell.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int LCNT_W = cntWidth(WIDTH);
  localparam logic [LCNT_W-1:0] LAST_BIT = LCNT_W'(WIDTH - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_sha;
  logic [WIDTH-1:0]  r_shb;
  logic [WIDTH-1:0]  r_psum;
  logic              r_carry;
  logic [LCNT_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_overflow;

  logic              w_f;
  logic              w_c;
  logic [WIDTH-1:0]  w_loadB;
  logic              w_loadCarry;

  full_adder_cell u_fa (
    .Ai (r_sha[0]),
    .Bi (r_shb[0]),
    .Ci (r_carry),
    .F  (w_f),
    .C  (w_c)
  );

  // Subtraction is a + ~b + 1, so only the B operand and initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_loadB     = sub ? ~b : b;
  assign w_loadCarry = sub ? 1'b1 : cin;
`else
  assign w_loadB     = b;
  assign w_loadCarry = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sha      <= '0;
      r_shb      <= '0;
      r_psum     <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sha   <= a;
            r_shb   <= w_loadB;
            r_carry <= w_loadCarry;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sha   <= r_sha >> 1;
          r_shb   <= r_shb >> 1;
          r_psum  <= {w_f, r_psum[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          // On the MSB, r_carry is the carry into the MSB, giving signed overflow.
          if (r_cnt == LAST_BIT) begin
            r_sum      <= {w_f, r_psum[WIDTH-1:1]};
            r_cout     <= w_c;
            r_overflow <= w_c ^ r_carry;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell (Ai, Bi, Ci -> F, C).
- Operands are loaded in parallel and shifted LSB-first through the cell, one bit per clock. The carry is registered and fed back as Ci.
- Sits directly upstream of the full-adder cell, sequencing its operand bits. Presents a start/done handshake to the datapath control.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  result register; holds last result
- cout  output  1  carry out of MSB; holds last result
- overflow  output  1  signed overflow (carry into MSB XOR carry out); holds last result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state: IDLE; busy=0, done=0, sum=0, cout=0, overflow=0. Internal shift regs, carry FF and counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 loads a->sha, b->shb, cin->carry FF, and clears bit counter to 0. Next state is RUN.
- RUN: each edge feeds sha[0], shb[0], carry into the full-adder cell.
  - F shifts into the MSB of the partial-sum shift reg; C goes into the carry FF.
  - sha and shb shift right; counter increments.
  - The carry into the MSB is captured when counter==WIDTH-1.
- On the edge where counter==WIDTH-1 (edge E_WIDTH):
  - final bit processed;
  - sum <= completed partial-sum (with the final F included), cout <= C, overflow <= C xor captured MSB carry-in;
  - state goes to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the start edge. Throughput is one add per WIDTH+2 cycles.
- busy=1 only in RUN.
- start in RUN or DONE is ignored; it is not queued.
- sum/cout/overflow change only on completion and are stable at all other times, including during the next RUN.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the same full sum.
- Reset mid-RUN: immediate abort, all outputs return to reset values, and no done is produced.
- a/b/cin changing after the start edge has no effect.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with start.
  - sub=1: shb loads ~b and the carry FF loads 1, so sum = a - b (cin ignored). cout=1 means no borrow. overflow is signed subtraction overflow.
  - sub=0: normal add.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the WIDTH default;
  - counter width constant CNT_W = clog2(WIDTH).
- One sub-module: full_adder_cell (ports Ai, Bi, Ci, F, C), purely combinational, instantiated once.
- The FSM, shift registers, counter and result registers live in serial_adder.

Test Plan:
- Reset, then a=8'h00, b=8'h00, cin=0, start -> done pulse exactly 8 cycles after the start edge; sum=8'h00, cout=0, overflow=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, overflow=0.
- Pulse start again at cycles 3 and 8 of a RUN -> ignored: exactly one done, result unchanged from the first operands. sum holds the previous value throughout RUN.
- Assert rst_n=0 at cycle 4 of a RUN of 8'h12+8'h34 -> outputs zero immediately, no done. A new start after release computes 8'h46 correctly.
- With SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, overflow=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1.
